lif_neuron_array: RTL and testbench

- Time-multiplexed array of N leaky integrate-and-fire neurons. All neurons share one update datapath; per-neuron state is held in register arrays.
- A `step` pulse starts one network timestep, which sweeps all neurons one per clock.
- Generalises the single Q4.4 neuron in three ways: parametrised width/format, channel count, and a selectable refractory mode (voltage-exit or cycle-count).
- Sits between the synaptic input stage and the spike-event encoder.

---
 rtl/lif_pkg.sv | 32 +++
 rtl/lif_update_core.sv | 87 ++++++++
 rtl/lif_neuron_array.sv | 152 +++++++++++++++
 tb/tb_lif_neuron_array.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// rtl/lif_pkg.sv - shared types, constants and saturation helper for the LIF neuron array
//
// Purpose: common definitions imported by lif_update_core and lif_neuron_array.
//   REFR_MODE_VOLT / REFR_MODE_CNT select how a neuron leaves refractory.
//   lif_state_t is the sweep FSM encoding.
//   sat() clamps a wide signed value into a w-bit two's complement range.
package lif_pkg;

  localparam int REFR_MODE_VOLT = 0;
  localparam int REFR_MODE_CNT  = 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } lif_state_t;

  // Width-generic clamp: the caller passes the target width and truncates the result.
  function automatic logic signed [31:0] sat(input logic signed [31:0] x, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (x > hi) begin
      return hi;
    end else if (x < lo) begin
      return lo;
    end else begin
      return x;
    end
  endfunction

endpackage

// File: rtl/lif_update_core.sv
// rtl/lif_update_core.sv - combinational next-state of one leaky integrate-and-fire neuron
//
// Purpose: given a neuron's stored membrane voltage, input current, refractory flag
// and refractory counter, produce the updated values and the spike bit.
// Ports:
//   i_v     W   current membrane voltage (signed)
//   i_i     W   input current (signed), ignored while refractory
//   i_refr  1   neuron is refractory
//   i_cnt   CW  remaining refractory timesteps (count mode only)
//   o_v     W   next membrane voltage
//   o_refr  1   next refractory flag
//   o_cnt   CW  next refractory counter
//   o_spike 1   neuron fires in this update
module lif_update_core
  import lif_pkg::*;
#(
  parameter int W          = 8,
  parameter int LSH        = 3,
  parameter int THRESH     = 64,
  parameter int V_MAX      = 127,
  parameter int V_RESET    = 0,
  parameter int NEG_DRIVE  = 16,
  parameter int REFR_MODE  = 0,
  parameter int REFR_STEPS = 4,
  parameter int CW         = 3
) (
  input  logic [W-1:0]  i_v,
  input  logic [W-1:0]  i_i,
  input  logic          i_refr,
  input  logic [CW-1:0] i_cnt,
  output logic [W-1:0]  o_v,
  output logic          o_refr,
  output logic [CW-1:0] o_cnt,
  output logic          o_spike
);

  logic signed [31:0] w_v;
  logic signed [31:0] w_i;
  logic signed [31:0] w_leak;
  logic signed [31:0] w_sum;

  assign w_v    = {{(32-W){i_v[W-1]}}, i_v};
  assign w_i    = {{(32-W){i_i[W-1]}}, i_i};
  // Arithmetic shift floors toward minus infinity, so negative V leaks toward zero.
  assign w_leak = w_v >>> LSH;

  always_comb begin
    w_sum   = '0;
    o_v     = i_v;
    o_refr  = i_refr;
    o_cnt   = i_cnt;
    o_spike = 1'b0;
    if (!i_refr) begin
      w_sum = sat(w_v + w_i - w_leak, W);
      if (w_sum >= THRESH) begin
        o_spike = 1'b1;
        o_refr  = 1'b1;
        if (REFR_MODE == REFR_MODE_CNT) begin
          o_v   = W'(V_RESET);
          o_cnt = CW'(REFR_STEPS);
        end else begin
          o_v = W'(V_MAX);
        end
      end else begin
        o_v = W'(w_sum);
      end
    end else if (REFR_MODE == REFR_MODE_VOLT) begin
      // Driven negative until the membrane undershoots -THRESH, then released.
      w_sum = sat(w_v - w_leak - NEG_DRIVE, W);
      o_v   = W'(w_sum);
      if (w_sum <= -THRESH) begin
        o_refr = 1'b0;
      end
    end else begin
      w_sum = sat(w_v - w_leak, W);
      o_v   = W'(w_sum);
      // A counter of 0 while refractory cannot normally occur; release rather than wrap.
      if (i_cnt <= CW'(1)) begin
        o_cnt  = '0;
        o_refr = 1'b0;
      end else begin
        o_cnt = i_cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/lif_neuron_array.sv
// rtl/lif_neuron_array.sv - time-multiplexed array of N leaky integrate-and-fire neurons
//
// Purpose: a step pulse latches all input currents and sweeps the neurons one per
// clock through a single shared lif_update_core; done pulses once the sweep ends.
// Ports:
//   clk        1     clock
//   rst        1     asynchronous active-high reset
//   step       1     start one timestep (accepted only while idle)
//   i_flat     N*W   input currents, neuron k at [k*W +: W]
//   busy       1     sweep in progress
//   done       1     one-cycle pulse, spike_vec/refr_vec valid
//   spike_vec  N     spikes of the last completed timestep
//   refr_vec   N     per-neuron refractory flags
//   rd_idx     log2N readout select
//   rd_v       W     stored V[rd_idx], one cycle latency
//   overrun    1     sticky, step arrived while busy
module lif_neuron_array
  import lif_pkg::*;
#(
  parameter int N          = 4,
  parameter int W          = 8,
  parameter int FRAC       = 4,
  parameter int LSH        = 3,
  parameter int THRESH     = 64,
  parameter int V_MAX      = 127,
  parameter int V_RESET    = 0,
  parameter int NEG_DRIVE  = 16,
  parameter int REFR_MODE  = 0,
  parameter int REFR_STEPS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   step,
  input  logic [N*W-1:0]         i_flat,
  output logic                   busy,
  output logic                   done,
  output logic [N-1:0]           spike_vec,
  output logic [N-1:0]           refr_vec,
  input  logic [$clog2(N)-1:0]   rd_idx,
  output logic [W-1:0]           rd_v,
  output logic                   overrun
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(REFR_STEPS + 1);

  // FRAC only names the fixed-point format; the datapath never depends on it.
  if (FRAC < 0 || FRAC >= W) begin : g_frac_outside_word
  end

  lif_state_t     r_state;
  logic [IW-1:0]  r_idx;
  logic [W-1:0]   r_v [N];
  logic [CW-1:0]  r_cnt [N];
  logic [N-1:0]   r_refr;
  logic [N-1:0]   r_shadow;
  logic [N-1:0]   r_spike_vec;
  logic [N*W-1:0] r_i_lat;
  logic           r_busy;
  logic           r_done;
  logic           r_overrun;
  logic [W-1:0]   r_rd_v;

  logic [W-1:0]   w_nv;
  logic           w_nrefr;
  logic [CW-1:0]  w_ncnt;
  logic           w_spike;
  logic [N-1:0]   w_shadow_next;

  lif_update_core #(
    .W          (W),
    .LSH        (LSH),
    .THRESH     (THRESH),
    .V_MAX      (V_MAX),
    .V_RESET    (V_RESET),
    .NEG_DRIVE  (NEG_DRIVE),
    .REFR_MODE  (REFR_MODE),
    .REFR_STEPS (REFR_STEPS),
    .CW         (CW)
  ) u_core (
    .i_v     (r_v[r_idx]),
    .i_i     (r_i_lat[r_idx*W +: W]),
    .i_refr  (r_refr[r_idx]),
    .i_cnt   (r_cnt[r_idx]),
    .o_v     (w_nv),
    .o_refr  (w_nrefr),
    .o_cnt   (w_ncnt),
    .o_spike (w_spike)
  );

  // Include the spike of the neuron being updated so the last one reaches spike_vec.
  assign w_shadow_next = r_shadow | (N'(w_spike) << r_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_refr      <= '0;
      r_shadow    <= '0;
      r_spike_vec <= '0;
      r_i_lat     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_overrun   <= 1'b0;
      r_rd_v      <= '0;
      for (int k = 0; k < N; k++) begin
        r_v[k]   <= '0;
        r_cnt[k] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      r_rd_v <= r_v[rd_idx];
      case (r_state)
        ST_IDLE: begin
          if (step) begin
            r_i_lat  <= i_flat;
            r_idx    <= '0;
            r_shadow <= '0;
            r_busy   <= 1'b1;
            r_state  <= ST_SWEEP;
          end
        end
        ST_SWEEP: begin
          if (step) begin
            r_overrun <= 1'b1;
          end
          r_v[r_idx]    <= w_nv;
          r_refr[r_idx] <= w_nrefr;
          r_cnt[r_idx]  <= w_ncnt;
          r_shadow      <= w_shadow_next;
          if (r_idx == IW'(N - 1)) begin
            r_spike_vec <= w_shadow_next;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign spike_vec = r_spike_vec;
  assign refr_vec  = r_refr;
  assign rd_v      = r_rd_v;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_lif_neuron_array.sv
// tb/tb_lif_neuron_array.sv - self-checking bench for lif_neuron_array in both refractory modes
module tb_lif_neuron_array;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           step;
  logic [N*W-1:0] i_flat;
  logic [1:0]     rd_idx;

  logic           busy_a, done_a, ovr_a;
  logic [N-1:0]   spk_a, refr_a;
  logic [W-1:0]   rdv_a;
  logic           busy_b, done_b, ovr_b;
  logic [N-1:0]   spk_b, refr_b;
  logic [W-1:0]   rdv_b;

  always #5 clk = ~clk;

  lif_neuron_array dut_a (
    .clk(clk), .rst(rst), .step(step), .i_flat(i_flat),
    .busy(busy_a), .done(done_a), .spike_vec(spk_a), .refr_vec(refr_a),
    .rd_idx(rd_idx), .rd_v(rdv_a), .overrun(ovr_a)
  );

  lif_neuron_array #(.REFR_MODE(1), .REFR_STEPS(2)) dut_b (
    .clk(clk), .rst(rst), .step(step), .i_flat(i_flat),
    .busy(busy_b), .done(done_b), .spike_vec(spk_b), .refr_vec(refr_b),
    .rd_idx(rd_idx), .rd_v(rdv_b), .overrun(ovr_b)
  );

  int checks = 0;
  int fails  = 0;

  // Reference state: index 0 = voltage-exit mode, 1 = count mode (2 steps).
  int mv [2][N];
  int mc [2][N];
  bit mr [2][N];
  bit ms [2][N];

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp8(input int x);
    if (x > 127) return 127;
    if (x < -128) return -128;
    return x;
  endfunction

  function automatic void model_reset();
    for (int m = 0; m < 2; m++)
      for (int k = 0; k < N; k++) begin
        mv[m][k] = 0; mc[m][k] = 0; mr[m][k] = 0; ms[m][k] = 0;
      end
  endfunction

  function automatic void model_step(input logic [N*W-1:0] flat);
    int v, cur, leak, nv;
    for (int m = 0; m < 2; m++)
      for (int k = 0; k < N; k++) begin
        v    = mv[m][k];
        cur  = $signed(flat[k*W +: W]);
        leak = v >>> 3;
        ms[m][k] = 0;
        if (!mr[m][k]) begin
          nv = clamp8(v + cur - leak);
          if (nv >= 64) begin
            ms[m][k] = 1;
            mr[m][k] = 1;
            mv[m][k] = (m == 0) ? 127 : 0;
            mc[m][k] = 2;
          end else begin
            mv[m][k] = nv;
          end
        end else if (m == 0) begin
          mv[m][k] = clamp8(v - leak - 16);
          if (mv[m][k] <= -64) mr[m][k] = 0;
        end else begin
          mv[m][k] = clamp8(v - leak);
          mc[m][k] = mc[m][k] - 1;
          if (mc[m][k] == 0) mr[m][k] = 0;
        end
      end
  endfunction

  task automatic start_step(input logic [N*W-1:0] flat, input bit at_neg);
    if (at_neg) @(negedge clk);
    i_flat = flat;
    step   = 1'b1;
    @(posedge clk);
    #1 step = 1'b0;
  endtask

  // Waits for done (bounded), optionally pulsing step mid-sweep, then checks vectors.
  task automatic finish_step(input logic [N*W-1:0] flat, input bit ovr);
    int lat;
    logic [N-1:0] es, er;
    lat = 0;
    do begin
      chk("busy_during_sweep", busy_a & busy_b, 1);
      if (ovr && lat == 2) step = 1'b1;
      @(posedge clk);
      #1 step = 1'b0;
      lat++;
    end while (!done_a && lat < 4 * N);
    chk("latency", lat, N);
    chk("done_a", done_a, 1);
    chk("done_b", done_b, 1);
    chk("busy_after", busy_a | busy_b, 0);
    if (ovr) begin
      chk("overrun_a", ovr_a, 1);
      chk("overrun_b", ovr_b, 1);
    end
    model_step(flat);
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < N; k++) begin
        es[k] = ms[m][k];
        er[k] = mr[m][k];
      end
      chk(m == 0 ? "spike_vec_a" : "spike_vec_b", m == 0 ? spk_a : spk_b, es);
      chk(m == 0 ? "refr_vec_a" : "refr_vec_b", m == 0 ? refr_a : refr_b, er);
    end
  endtask

  task automatic check_v();
    for (int k = 0; k < N; k++) begin
      rd_idx = 2'(k);
      @(posedge clk);
      #1;
      if (k == 0) chk("done_single_cycle", done_a | done_b, 0);
      chk("rd_v_a", $signed(rdv_a), mv[0][k]);
      chk("rd_v_b", $signed(rdv_b), mv[1][k]);
    end
  endtask

  logic [N*W-1:0] flat;

  initial begin
    rst = 1'b1; step = 1'b0; i_flat = '0; rd_idx = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy_a | busy_b, 0);
    chk("rst_done", done_a | done_b, 0);
    chk("rst_spike", spk_a | spk_b, 0);
    chk("rst_refr", refr_a | refr_b, 0);
    chk("rst_overrun", ovr_a | ovr_b, 0);
    chk("rst_rd_v", rdv_a | rdv_b, 0);
    rst = 1'b0;

    // Neuron 0 driven with 32, others idle: integrate, spike, refractory recovery.
    flat = {8'd0, 8'd0, 8'd0, 8'd32};
    for (int s = 0; s < 15; s++) begin
      start_step(flat, 1'b1);
      finish_step(flat, 1'b0);
      check_v();
    end

    // Step pulsed mid-sweep is ignored and flags overrun; step in done cycle is accepted.
    flat = {8'd5, 8'd10, 8'd20, 8'd30};
    start_step(flat, 1'b1);
    finish_step(flat, 1'b1);
    start_step(flat, 1'b0);
    chk("accept_in_done_cycle", busy_a & busy_b, 1);
    finish_step(flat, 1'b0);
    check_v();

    // Negative saturation on neuron 1.
    flat = {8'd0, 8'd0, 8'h80, 8'd0};
    for (int s = 0; s < 2; s++) begin
      start_step(flat, 1'b1);
      finish_step(flat, 1'b0);
      check_v();
    end

    // Reset mid-sweep aborts everything, including the sticky overrun.
    start_step({8'd40, 8'd40, 8'd40, 8'd40}, 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_busy", busy_a | busy_b, 0);
    chk("midrst_done", done_a | done_b, 0);
    chk("midrst_spike", spk_a | spk_b, 0);
    chk("midrst_refr", refr_a | refr_b, 0);
    chk("midrst_overrun", ovr_a | ovr_b, 0);
    model_reset();
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1 chk("midrst_no_done", done_a | done_b, 0);
    end
    rst = 1'b0;
    check_v();

    // All channels at once from a clean state.
    flat = {8'hF0, 8'h00, 8'h3F, 8'h40};
    start_step(flat, 1'b1);
    finish_step(flat, 1'b0);
    chk("multi_spike_a", spk_a, 4'b0001);
    rd_idx = 2'd3;
    @(posedge clk);
    #1 chk("multi_rd3", $signed(rdv_a), -16);
    check_v();

    // Randomized currents against the reference model.
    for (int s = 0; s < 40; s++) begin
      for (int k = 0; k < N; k++) begin
        if (s % 5 == 4) flat[k*W +: W] = 8'($urandom_range(255));
        else            flat[k*W +: W] = 8'(int'($urandom_range(96)) - 32);
      end
      start_step(flat, 1'b1);
      finish_step(flat, 1'b0);
      check_v();
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
